// File: rtl/digdug_clk_pkg.sv
// Shared state encoding and default timing constants for the Dig Dug clock/reset block.
// Defaults assume the 49.147727 MHz PLL clock.
package digdug_clk_pkg;

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_HOLD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  localparam int DEF_LOCK_HOLD = 1024;
  localparam int DEF_PIX_DIV   = 8;
  localparam int DEF_CPU_DIV   = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Both flops clear asynchronously on rst_n.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the async level through two flops to settle metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/digdug_clock_reset.sv
// Core reset sequencer and clock-enable generator: qualifies PLL lock for LOCK_HOLD cycles,
// then releases core_rst_n and produces pixel/CPU enable pulses in the clk domain.
module digdug_clock_reset
  import digdug_clk_pkg::*;
#(
  parameter int LOCK_HOLD = DEF_LOCK_HOLD,
  parameter int PIX_DIV   = DEF_PIX_DIV,
  parameter int CPU_DIV   = DEF_CPU_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pll_locked,
  input  logic pause,
  output logic core_rst_n,
  output logic ce_pix,
  output logic ce_cpu,
  output logic running
);

  localparam int HOLD_W = (LOCK_HOLD > 1) ? $clog2(LOCK_HOLD) : 1;
  localparam int DIV_W  = $clog2(CPU_DIV);
  localparam int PIX_W  = $clog2(PIX_DIV);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LOCK_HOLD - 1);

  logic              lock_s;
  state_t            state;
  state_t            state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_nxt;
  logic [DIV_W-1:0]  div_cnt;
  logic              in_run;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  // State and hold-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_WAIT;
      hold_cnt <= {HOLD_W{1'b0}};
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Lock qualification: any synchronized low restarts the full hold window.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    case (state)
      S_WAIT: begin
        if (lock_s) begin
          hold_nxt  = {HOLD_W{1'b0}};
          state_nxt = S_HOLD;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_HOLD: begin
        if (!lock_s) begin
          state_nxt = S_WAIT;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nxt = S_RUN;
        end else begin
          hold_nxt = hold_cnt + HOLD_W'(1);
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          state_nxt = S_WAIT;
        end else begin
          state_nxt = S_RUN;
        end
      end
      default: begin
        state_nxt = S_WAIT;
        hold_nxt  = {HOLD_W{1'b0}};
      end
    endcase
  end

  assign in_run = (state == S_RUN);

  // Registered reset/run flags, divider and enables; enables are gated by the
  // state so none can fire on the edge that drops core_rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_rst_n <= 1'b0;
      running    <= 1'b0;
      div_cnt    <= {DIV_W{1'b0}};
      ce_pix     <= 1'b0;
      ce_cpu     <= 1'b0;
    end else begin
      core_rst_n <= in_run;
      running    <= in_run;
      div_cnt    <= core_rst_n ? (div_cnt + DIV_W'(1)) : {DIV_W{1'b0}};
      ce_pix     <= in_run && (div_cnt[PIX_W-1:0] == {PIX_W{1'b1}});
      ce_cpu     <= in_run && (div_cnt == {DIV_W{1'b1}}) && !pause;
    end
  end

endmodule

// File: tb/tb_digdug_clock_reset.sv
// Scoreboard bench for digdug_clock_reset: a run-length lock model predicts every
// cycle's outputs, and an independent monitor compares them after each clock edge.
module tb_digdug_clock_reset;

  localparam int LH   = 16;
  localparam int PIXD = 8;
  localparam int CPUD = 16;

  typedef struct packed {
    logic core;
    logic run;
    logic pix;
    logic cpu;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pll_locked = 1'b0;
  logic pause = 1'b0;
  logic core_rst_n, ce_pix, ce_cpu, running;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  // model state: consecutive high lock samples, last few run lengths, rise edge
  int   run_len = 0;
  int   hist[$];
  logic core_prev = 1'b0;
  int   edge_n = 0;
  int   rise_edge = 0;

  digdug_clock_reset #(
    .LOCK_HOLD (LH),
    .PIX_DIV   (PIXD),
    .CPU_DIV   (CPUD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .pause      (pause),
    .core_rst_n (core_rst_n),
    .ce_pix     (ce_pix),
    .ce_cpu     (ce_cpu),
    .running    (running)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s t=%0t got=%0b expected=%0b", name, $time, act, req);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the prediction for the next rising edge.
  task automatic step(input logic rst_v, input logic lock_v, input logic pause_v);
    exp_t e;
    logic core;
    @(negedge clk);
    rst_n      = rst_v;
    pll_locked = lock_v;
    pause      = pause_v;
    edge_n++;
    if (!rst_v) begin
      run_len   = 0;
      hist      = {};
      core_prev = 1'b0;
      e         = '0;
    end else begin
      run_len = lock_v ? run_len + 1 : 0;
      hist.push_back(run_len);
      if (hist.size() > 4) void'(hist.pop_front());
      core = (hist.size() == 4) && (hist[0] >= LH + 1);
      if (core && !core_prev) rise_edge = edge_n;
      e.core = core;
      e.run  = core;
      e.pix  = core && core_prev && ((edge_n - rise_edge) % PIXD == 0);
      e.cpu  = e.pix && ((edge_n - rise_edge) % CPUD == 0) && !pause_v;
      core_prev = core;
    end
    exp_q.push_back(e);
  endtask

  // Monitor: compare the DUT against the oldest prediction shortly after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("core_rst_n", core_rst_n, e.core);
        check("running",    running,    e.run);
        check("ce_pix",     ce_pix,     e.pix);
        check("ce_cpu",     ce_cpu,     e.cpu);
      end
    end
  end

  initial begin
    // reset held, then release with lock high from the first edge
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    check("reset_core", core_rst_n, 1'b0);
    check("reset_ce",   ce_pix | ce_cpu | running, 1'b0);
    for (int i = 0; i < 60; i++) step(1'b1, 1'b1, 1'b0);
    // pause for 40 clocks, then random pause
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 30; i++) step(1'b1, 1'b1, 1'($urandom_range(0, 1)));
    // single-cycle loss of lock while running
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0);
    // glitch during qualification around hold count 10
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0);
    // random lock drop-outs and pause
    for (int i = 0; i < 300; i++)
      step(1'b1, 1'($urandom_range(0, 29) != 0), 1'($urandom_range(0, 3) == 0));
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0);
    // asynchronous reset between edges while running
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_core_rst_n", core_rst_n, 1'b0);
    check("async_running",    running,    1'b0);
    check("async_ce_pix",     ce_pix,     1'b0);
    check("async_ce_cpu",     ce_cpu,     1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 60; i++) step(1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    check("queue_drained", exp_q.size() == 0, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
